bitfusion_ctrl: RTL and testbench

//  Sequencer for the bitfusion systolic array. Takes a start command plus bitwidth config and

---
 rtl/bitfusion_ctrl_pkg.sv | 42 ++++
 rtl/bitfusion_wavefront.sv | 32 +++
 rtl/bitfusion_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_bitfusion_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitfusion_ctrl_pkg.sv
// Shared types and helpers for the bitfusion sequencer: FSM states, one-hot
// bitwidth codes and the compute-beat count derived from the bitwidth pair.
package bitfusion_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_W,
        S_CLEAR,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    typedef logic [2:0] bw_code_t;

    localparam bw_code_t BW_2 = 3'b001;
    localparam bw_code_t BW_4 = 3'b010;
    localparam bw_code_t BW_8 = 3'b100;

    function automatic logic bw_valid(bw_code_t code);
        return (code == BW_2) || (code == BW_4) || (code == BW_8);
    endfunction

    function automatic int bw_bits(bw_code_t code);
        case (code)
            BW_2:    return 2;
            BW_4:    return 4;
            BW_8:    return 8;
            default: return 0;
        endcase
    endfunction

    // Narrower operand sets how many bit-slices of a buffer word each FU must stream.
    function automatic int beats_f(bw_code_t in_bw, bw_code_t wt_bw, int data_w);
        int bi;
        int bw;
        bi = bw_bits(in_bw);
        bw = bw_bits(wt_bw);
        return data_w * ((bi < bw) ? bi : bw) / 64;
    endfunction

endpackage

// File: rtl/bitfusion_wavefront.sv
// Diagonal read-enable generator: FU [r][c] is enabled for BEATS cycles
// starting at compute cycle r+c. Outputs are registered.
module bitfusion_wavefront #(
    parameter int N   = 2,
    parameter int T_W = 3,
    parameter int B_W = 3
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [T_W-1:0]   t,
    input  logic [B_W-1:0]   beats,
    input  logic             active,
    output logic [N*N-1:0]   weight_rd_en,
    output logic [N-1:0]     input_rd_en
);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            weight_rd_en <= '0;
            input_rd_en  <= '0;
        end else begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    weight_rd_en[r*N+c] <= active && (int'(t) >= r + c)
                                           && (int'(t) < r + c + int'(beats));
                end
                input_rd_en[r] <= active && (int'(t) >= r) && (int'(t) < r + int'(beats));
            end
        end
    end

endmodule

// File: rtl/bitfusion_ctrl.sv
// Bitfusion array sequencer: load IBUF/WBUF over a valid/ready port, optional
// accumulator clear, diagonal compute wavefront, drain, done. Optional
// BITFUSION_CTRL_PERF_EN adds busy/stall cycle counters.
module bitfusion_ctrl
    import bitfusion_ctrl_pkg::*;
#(
    parameter int ARRAY_SIZE   = 2,
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           nRST,
    input  logic                           start,
    input  logic [2:0]                     cfg_in_bw,
    input  logic [2:0]                     cfg_wt_bw,
    input  logic                           cfg_load_wt,
    input  logic                           cfg_clear,
    input  logic                           ld_valid,
    input  logic [DATA_W-1:0]              ld_data,
    output logic                           ld_ready,
    output logic [DATA_W-1:0]              data_in,
    output logic [ARRAY_SIZE-1:0]          IBUF_wr_en,
    output logic [ARRAY_SIZE*ARRAY_SIZE-1:0] WBUF_wr_en,
    output logic [ARRAY_SIZE-1:0]          input_rd_en,
    output logic [ARRAY_SIZE*ARRAY_SIZE-1:0] weight_rd_en,
    output logic [ARRAY_SIZE-1:0]          acc_clear,
    output logic [2:0]                     input_bitwidth,
    output logic [2:0]                     weight_bitwidth,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err,
    output state_t                         fsm_state
`ifdef BITFUSION_CTRL_PERF_EN
    ,
    output logic [31:0]                    perf_busy_cyc,
    output logic [31:0]                    perf_stall_cyc
`endif
);

    localparam int N         = ARRAY_SIZE;
    localparam int MAX_BEATS = DATA_W / 8;
    localparam int T_W       = $clog2(2*N + MAX_BEATS);
    localparam int B_W       = $clog2(MAX_BEATS + 1);
    localparam int K_W       = $clog2(N*N + 1);
    localparam int D_W       = $clog2(DRAIN_CYCLES + 1);

    state_t         state;
    logic [K_W-1:0] word_cnt;
    logic [T_W-1:0] t;
    logic [T_W-1:0] t_last;
    logic [D_W-1:0] drain_cnt;
    logic [B_W-1:0] beats;
    logic           load_wt;
    logic           clear_en;
    logic           cfg_ok;
    logic           handshake;
    state_t         post_load_state;

    assign cfg_ok          = bw_valid(cfg_in_bw) && bw_valid(cfg_wt_bw);
    assign handshake       = ld_valid && ld_ready;
    assign beats           = B_W'(beats_f(input_bitwidth, weight_bitwidth, DATA_W));
    assign t_last          = T_W'(2*(N-1) + int'(beats) - 1);
    assign post_load_state = clear_en ? S_CLEAR : S_COMPUTE;
    assign fsm_state       = state;

    // ld_ready is a registered level: high for every cycle of the load states,
    // dropped on the edge that accepts the final word of the phase.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state           <= S_IDLE;
            word_cnt        <= '0;
            t               <= '0;
            drain_cnt       <= '0;
            load_wt         <= 1'b0;
            clear_en        <= 1'b0;
            ld_ready        <= 1'b0;
            data_in         <= '0;
            IBUF_wr_en      <= '0;
            WBUF_wr_en      <= '0;
            acc_clear       <= '0;
            input_bitwidth  <= '0;
            weight_bitwidth <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;
        end else begin
            IBUF_wr_en <= '0;
            WBUF_wr_en <= '0;
            acc_clear  <= '0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            input_bitwidth  <= cfg_in_bw;
                            weight_bitwidth <= cfg_wt_bw;
                            load_wt         <= cfg_load_wt;
                            clear_en        <= cfg_clear;
                            cfg_err         <= 1'b0;
                            busy            <= 1'b1;
                            ld_ready        <= 1'b1;
                            word_cnt        <= '0;
                            state           <= S_LOAD_I;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_LOAD_I: begin
                    if (handshake) begin
                        data_in    <= ld_data;
                        IBUF_wr_en <= N'(1) << word_cnt;
                        if (word_cnt == K_W'(N-1)) begin
                            word_cnt <= '0;
                            if (load_wt) begin
                                state <= S_LOAD_W;
                            end else begin
                                ld_ready  <= 1'b0;
                                acc_clear <= {N{clear_en}};
                                t         <= '0;
                                state     <= post_load_state;
                            end
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_W: begin
                    if (handshake) begin
                        data_in    <= ld_data;
                        WBUF_wr_en <= (N*N)'(1) << word_cnt;
                        if (word_cnt == K_W'(N*N-1)) begin
                            word_cnt  <= '0;
                            ld_ready  <= 1'b0;
                            acc_clear <= {N{clear_en}};
                            t         <= '0;
                            state     <= post_load_state;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    t     <= '0;
                    state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (t == t_last) begin
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Enables lag the state by one register, so the drain window
                    // is counted from the last visible enable.
                    if (drain_cnt == D_W'(DRAIN_CYCLES)) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                        if (drain_cnt == D_W'(DRAIN_CYCLES-1)) done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    bitfusion_wavefront #(
        .N   (N),
        .T_W (T_W),
        .B_W (B_W)
    ) u_wavefront (
        .clk          (clk),
        .nRST         (nRST),
        .t            (t),
        .beats        (beats),
        .active       (state == S_COMPUTE),
        .weight_rd_en (weight_rd_en),
        .input_rd_en  (input_rd_en)
    );

`ifdef BITFUSION_CTRL_PERF_EN
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if (state == S_IDLE && start && cfg_ok) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 1'b1;
            if ((state == S_LOAD_I || state == S_LOAD_W) && !ld_valid && perf_stall_cyc != '1)
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bitfusion_ctrl.sv
// Self-checking bench for bitfusion_ctrl: directed runs against a cycle model
// of writes, wavefront, done, busy and cfg_err.
module tb_bitfusion_ctrl;
    import bitfusion_ctrl_pkg::*;

    localparam int N     = 2;
    localparam int DW    = 32;
    localparam int DC    = 4;
    localparam int WQ_W  = N*N + N + 1;
    localparam int XW    = DW + N + N*N;

    logic              clk;
    logic              nRST;
    logic              start;
    logic [2:0]        cfg_in_bw;
    logic [2:0]        cfg_wt_bw;
    logic              cfg_load_wt;
    logic              cfg_clear;
    logic              ld_valid;
    logic [DW-1:0]     ld_data;
    logic              ld_ready;
    logic [DW-1:0]     data_in;
    logic [N-1:0]      IBUF_wr_en;
    logic [N*N-1:0]    WBUF_wr_en;
    logic [N-1:0]      input_rd_en;
    logic [N*N-1:0]    weight_rd_en;
    logic [N-1:0]      acc_clear;
    logic [2:0]        input_bitwidth;
    logic [2:0]        weight_bitwidth;
    logic              busy;
    logic              done;
    logic              cfg_err;
    state_t            fsm_state;

    bitfusion_ctrl #(.ARRAY_SIZE(N), .DATA_W(DW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .nRST(nRST), .start(start), .cfg_in_bw(cfg_in_bw), .cfg_wt_bw(cfg_wt_bw),
        .cfg_load_wt(cfg_load_wt), .cfg_clear(cfg_clear), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .data_in(data_in), .IBUF_wr_en(IBUF_wr_en), .WBUF_wr_en(WBUF_wr_en),
        .input_rd_en(input_rd_en), .weight_rd_en(weight_rd_en), .acc_clear(acc_clear),
        .input_bitwidth(input_bitwidth), .weight_bitwidth(weight_bitwidth), .busy(busy),
        .done(done), .cfg_err(cfg_err), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [XW-1:0]   exp_q[$];
    logic [WQ_W-1:0] wave_q[$];
    logic [N*N-1:0]  act_w[$];
    logic [N-1:0]    act_i[$];
    logic            act_d[$];
    int              m_word;
    bit              m_busy, m_err, m_cl, started;
    logic [DW-1:0]   last_data;
    int              dones_seen = 0;
    int              clr_cnt = 0;
    logic [XW-1:0]   wexp;
    logic [WQ_W-1:0] wv;
    logic [N-1:0]    ib;
    logic [N*N-1:0]  wb;
    bit              wave_done;

    function automatic int model_beats(logic [2:0] ibw, logic [2:0] wbw);
        int bi = 2 * int'(ibw);
        int bw = 2 * int'(wbw);
        return DW * ((bi < bw) ? bi : bw) / 64;
    endfunction

    task automatic push_wave(input logic [2:0] ibw, input logic [2:0] wbw);
        int beats = model_beats(ibw, wbw);
        logic [N*N-1:0] w;
        logic [N-1:0]   i;
        for (int t = 0; t < 2*(N-1) + beats; t++) begin
            w = '0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    if (t >= r + c && t < r + c + beats) w[r*N+c] = 1'b1;
            for (int r = 0; r < N; r++) i[r] = w[r*N];
            wave_q.push_back({w, i, 1'b0});
        end
        for (int d = 0; d < DC; d++) wave_q.push_back({{(N*N+N){1'b0}}, d == DC-1});
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!nRST) begin
            exp_q.delete();
            wave_q.delete();
            m_busy = 0; m_err = 0; started = 0; m_word = 0; last_data = '0;
        end else begin
            if (exp_q.size() > 0) begin
                wexp = exp_q.pop_front();
                check("write", {data_in, IBUF_wr_en, WBUF_wr_en}, wexp);
                last_data = wexp[XW-1 -: DW];
            end else begin
                check("no_write", {IBUF_wr_en, WBUF_wr_en}, 0);
                check("data_hold", data_in, last_data);
            end
            if (ld_valid && ld_ready) begin
                ib = '0; wb = '0;
                if (m_word < N) ib[m_word] = 1'b1;
                else wb[m_word-N] = 1'b1;
                exp_q.push_back({ld_data, ib, wb});
                m_word++;
            end
            wave_done = 0;
            if (wave_q.size() > 0 && (started || weight_rd_en != '0 || input_rd_en != '0)) begin
                started = 1;
                wv = wave_q.pop_front();
                check("wave", {weight_rd_en, input_rd_en, done}, wv);
                act_w.push_back(weight_rd_en);
                act_i.push_back(input_rd_en);
                act_d.push_back(done);
                if (wv[0]) begin wave_done = 1; dones_seen++; end
                if (wave_q.size() == 0) started = 0;
            end else begin
                check("idle_wave", {weight_rd_en, input_rd_en, done}, 0);
            end
            if (acc_clear != '0) begin
                check("acc_clear", {acc_clear, m_cl, started}, {{N{1'b1}}, 1'b1, 1'b0});
                clr_cnt++;
            end
            check("busy", busy, m_busy);
            check("cfg_err", cfg_err, m_err);
            if (wave_done) m_busy = 0;
            if (start && !m_busy) begin
                if ($onehot(cfg_in_bw) && $onehot(cfg_wt_bw)) begin
                    m_busy = 1; m_err = 0; m_word = 0; m_cl = cfg_clear;
                    push_wave(cfg_in_bw, cfg_wt_bw);
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [2:0] ibw, input logic [2:0] wbw, input logic lw,
                             input logic cl);
        act_w.delete(); act_i.delete(); act_d.delete();
        clr_cnt = 0;
        cfg_in_bw = ibw; cfg_wt_bw = wbw; cfg_load_wt = lw; cfg_clear = cl;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_words(input logic lw, input logic [DW-1:0] iw, input logic [DW-1:0] ww,
                              input int gap_max, input bit rnd);
        int nwords = N + (lw ? N*N : 0);
        int w;
        for (int k = 0; k < nwords; k++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            ld_valid = 1'b1;
            ld_data  = rnd ? DW'($urandom) : ((k < N) ? iw : ww);
            w = 0;
            while (!ld_ready && w < 20) begin tick(); w++; end
            if (!ld_ready) begin
                check("ld_ready_timeout", 0, 1);
                ld_valid = 1'b0;
                return;
            end
            tick();
            ld_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int d0, input logic cl);
        for (int i = 0; i < 300 && dones_seen == d0; i++) tick();
        check("done_seen", dones_seen, d0 + 1);
        tick();
        tick();
        check("acc_clear_cycles", clr_cnt, cl);
    endtask

    task automatic drive_run(input logic [2:0] ibw, input logic [2:0] wbw, input logic lw,
                             input logic cl, input logic [DW-1:0] iw, input logic [DW-1:0] ww,
                             input int gap_max, input bit rnd);
        int d0 = dones_seen;
        start_run(ibw, wbw, lw, cl);
        load_words(lw, iw, ww, gap_max, rnd);
        wait_done(d0, cl);
    endtask

    logic [N*N-1:0] lit_w [4] = '{4'b0001, 4'b0111, 4'b1110, 4'b1000};
    logic [N-1:0]   lit_i [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    task automatic check_test1_literals();
        check("t1_len", act_w.size(), 8);
        if (act_w.size() != 8) return;
        for (int i = 0; i < 4; i++) begin
            check("t1_weight_rd_en", act_w[i], lit_w[i]);
            check("t1_input_rd_en", act_i[i], lit_i[i]);
        end
        check("t1_done_pos", {act_d[3], act_d[6], act_d[7]}, 3'b001);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        int nz;
        nRST = 1'b0; start = 1'b0; cfg_in_bw = '0; cfg_wt_bw = '0;
        cfg_load_wt = 1'b0; cfg_clear = 1'b0; ld_valid = 1'b0; ld_data = '0;
        repeat (3) tick();
        check("rst_ready_busy_done_err", {ld_ready, busy, done, cfg_err}, 0);
        check("rst_data_in", data_in, 0);
        check("rst_wr_en", {IBUF_wr_en, WBUF_wr_en}, 0);
        check("rst_rd_en_clear", {input_rd_en, weight_rd_en, acc_clear}, 0);
        check("rst_bitwidth", {input_bitwidth, weight_bitwidth}, 0);
        nRST = 1'b1;
        tick();

        check("pin_beats_8x4", model_beats(3'b100, 3'b010), 2);
        check("pin_beats_2x2", model_beats(3'b001, 3'b001), 1);
        check("pin_beats_8x8", model_beats(3'b100, 3'b100), 4);

        // 1: 8b x 4b, full load, no clear
        drive_run(3'b100, 3'b010, 1'b1, 1'b0, 32'h7f7f7f7f, 32'h77777777, 0, 0);
        check_test1_literals();
        check("t1_bitwidths", {input_bitwidth, weight_bitwidth}, {3'b100, 3'b010});

        // 2: 2b x 2b, BEATS=1
        drive_run(3'b001, 3'b001, 1'b1, 1'b0, 32'h55555555, 32'h55555555, 0, 0);
        nz = 0;
        foreach (act_w[i]) if (act_w[i] != '0) nz++;
        check("t2_compute_cycles", nz, 3);

        // 3: random gaps and data, 8b x 8b
        drive_run(3'b100, 3'b100, 1'b1, 1'b0, '0, '0, 3, 1);

        // 4: reuse weights, clear accumulators
        drive_run(3'b010, 3'b100, 1'b0, 1'b1, 32'ha5a5a5a5, '0, 1, 0);

        // 5: bad bitwidth, then recovery
        cfg_in_bw = 3'b011; cfg_wt_bw = 3'b010; cfg_load_wt = 1'b1; cfg_clear = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hdeadbeef;
        repeat (3) tick();
        check("t5_err_state", {cfg_err, busy, ld_ready}, 3'b100);
        ld_valid = 1'b0;
        drive_run(3'b001, 3'b100, 1'b1, 1'b1, 32'h12345678, 32'h9abcdef0, 0, 0);
        check("t5_err_cleared", cfg_err, 0);

        // 6: reset during compute, then clean rerun of test 1
        d0 = dones_seen;
        start_run(3'b100, 3'b010, 1'b1, 1'b0);
        load_words(1'b1, 32'h7f7f7f7f, 32'h77777777, 0, 0);
        for (int i = 0; i < 50 && act_w.size() < 2; i++) tick();
        check("t6_reached_compute", act_w.size() >= 2, 1);
        nRST = 1'b0;
        #1;
        check("t6_rst_enables", {weight_rd_en, input_rd_en}, 0);
        check("t6_rst_busy_done", {busy, done}, 0);
        repeat (10) tick();
        nRST = 1'b1;
        repeat (10) tick();
        check("t6_no_done", dones_seen, d0);
        drive_run(3'b100, 3'b010, 1'b1, 1'b0, 32'h7f7f7f7f, 32'h77777777, 0, 0);
        check_test1_literals();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
